// File: rtl/mux_pkg.sv
// mux_pkg: shared constants, mode encoding and width helper for the
// N-channel registered multiplexer family.
package mux_pkg;

    // Largest channel count the mux family is built for.
    localparam int unsigned MUX_MAX_N = 16;

    // Channel selection modes; values match the rr_mode pin level.
    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    // Index width for n channels: ceil(log2(n)), never less than one bit.
    function automatic int unsigned mux_selw(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_nch_reg_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin grant. Searches the request
// vector from the pointer upward, wrapping modulo N, and returns the first
// requester as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    // First requester at or after ptr, wrapping past N-1 back to 0.
    always_comb begin
        int unsigned c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = (32'(ptr) + k) % N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = SELW'(c);
            end
        end
    end

endmodule

// File: rtl/mux_nch_reg.sv
// mux_nch_reg: N-channel, W-bit registered multiplexer with per-channel
// valid/ready, a one-entry output register and optional round-robin mode.
// Build option: define MUX_NCH_RR_EN to include the round-robin arbiter and
// its pointer register; without it rr_mode is ignored and the block is
// select-only.
// In round-robin mode in_ready depends combinationally on in_valid (the
// arbiter looks at the requests). In select mode it does not.
module mux_nch_reg
    import mux_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned SELW = mux_selw(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    input  logic            rr_mode,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    mux_mode_e       mode;
    logic [N-1:0]    grant_sel;
    logic [N-1:0]    grant;
    logic [SELW-1:0] gidx;
    logic [W-1:0]    word;
    logic            load;
    logic            xfer;

    // Explicit select: one-hot on sel; sel >= N matches no channel.
    always_comb begin
        grant_sel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == SELW'(i)) begin
                grant_sel[i] = 1'b1;
            end
        end
    end

`ifdef MUX_NCH_RR_EN
    logic [SELW-1:0] rr_ptr;
    logic [N-1:0]    grant_rr;
    logic [SELW-1:0] idx_rr;
    logic            any_rr;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_arbiter (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (grant_rr),
        .idx   (idx_rr),
        .any   (any_rr)
    );

    assign mode  = rr_mode ? MODE_RR : MODE_SEL;
    assign grant = (mode == MODE_RR) ? grant_rr : grant_sel;

    // Pointer advances past the granted channel on round-robin transfers only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer && mode == MODE_RR) begin
            rr_ptr <= (gidx == SELW'(N-1)) ? '0 : gidx + SELW'(1);
        end
    end
`else
    logic unused_rr_mode;

    assign unused_rr_mode = rr_mode;
    assign mode           = MODE_SEL;
    assign grant          = grant_sel;
`endif

    // Encode the granted channel and route its word towards the register.
    always_comb begin
        gidx = '0;
        word = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) begin
                gidx = SELW'(i);
                word = in_data[i*W +: W];
            end
        end
    end

    // Register can take a word when empty or when its word leaves this cycle.
    assign load     = !out_valid || out_ready;
    assign in_ready = load ? grant : '0;
    assign xfer     = load && |(grant & in_valid);

    // One-entry output register; a simultaneous consume and load overwrites.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= word;
            out_chan  <= gidx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_nch_reg.md
# mux_nch_reg

Parametrised N-channel, W-bit registered multiplexer: the successor to the fixed 4:1 single-bit combinational mux. It adds per-channel valid/ready handshakes, a one-entry output register and an optional round-robin selection mode. It sits between several producers and a single consumer and forwards one word per cycle from the selected channel.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `W`, default 8: data width per channel, at least 1.
- `SELW`, default `$clog2(N)`: select/channel-index width. Derived; do not override.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready; combinational.
- `sel`  in  SELW  explicit channel select, used in select mode.
- `rr_mode`  in  1  1 = round-robin, 0 = explicit select.
- `out_data`  out  W  registered output word.
- `out_chan`  out  SELW  source channel of `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- Grant is one-hot, combinational, at most one bit set.
  - Select mode: grant = channel `sel`. A `sel` value of N or more grants nothing.
  - Round-robin mode: grant = first channel with `in_valid` high, searching from pointer `rr_ptr` upward and wrapping modulo N.
- `load` = `!out_valid || out_ready`.
- `in_ready[i]` = `grant[i] && load`. A channel is ready regardless of its own valid; its transfer occurs only when valid is also high.
- On a transfer from channel g: `out_data` <= word g, `out_chan` <= g, `out_valid` <= 1.
- Output consumed (`out_valid && out_ready`) with no new transfer: `out_valid` <= 0. `out_data` and `out_chan` hold their values.
- Consume and transfer in the same cycle: the new word replaces the old one, so throughput is 1 word per cycle.
- `rr_ptr` <= (g+1) mod N after each transfer in round-robin mode only. It is unchanged in select mode and on idle cycles.
- `rr_mode` and `sel` may change on any cycle and take effect the same cycle. A switch between modes does not reset `rr_ptr`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `rr_ptr`=0. `in_ready` follows combinationally and is therefore 0 while `out_valid`=0 only if no channel is granted.
- Latency: word accepted at edge k is visible on `out_data`/`out_valid` after edge k and is consumable in cycle k+1.
- Backpressure: while `out_valid && !out_ready`, all `in_ready` are 0 and the output register is stable. Producers must hold their data.
- Reset asserted mid-transfer clears the output register immediately (asynchronous); the held word is lost. Deassertion is synchronised by the caller.
- Round-robin wrap: a grant to N-1 sets `rr_ptr` to 0.
- No combinational path from `in_valid` to `in_ready` in select mode. In round-robin mode that path exists and is documented.

## Configuration
- `MUX_NCH_RR_EN` defined: round-robin logic and `rr_ptr` are built, and `rr_mode` behaves as above.
- Not defined: `rr_mode` is ignored (treated as 0), there is no `rr_ptr` register, and the block is select-only.

## Structure
- Package `mux_pkg`:
  - `MUX_MAX_N` = 16.
  - Width helper function for SELW.
  - Mode constants `MODE_SEL` = 0 and `MODE_RR` = 1.
- Sub-module `rr_arbiter`: N-bit request, SELW pointer, one-hot grant plus encoded index, purely combinational. Instantiated only under `MUX_NCH_RR_EN`.
- Top level: grant muxing, output register, pointer register.

## Test plan
- Reset: hold `rst_n`=0 with random inputs. Require `out_valid`=0, `out_data`=0x00, `out_chan`=0. Release, `rr_mode`=0, `sel`=2, `in_valid`=4'b0100, ch2=0xA5. Require `out_data`=0xA5, `out_chan`=2 after 1 edge.
- Backpressure: output holds 0xA5 and `out_ready`=0 for 3 cycles. Require all `in_ready`=0 and output stable. Raise `out_ready` with ch2=0x5A. Require back-to-back transfer of 0x5A with no bubble.
- Out-of-range select: N=3, `sel`=3, all valid. Require `in_ready`=0 and `out_valid` falling to 0 after the pending word is consumed.
- Round-robin fairness (macro on): `rr_mode`=1, all 4 valid, `out_ready`=1. Require `out_chan` sequence 0,1,2,3,0 on consecutive cycles.
- Round-robin skip and wrap: `in_valid`=4'b1001, `rr_ptr`=1. Require grant 3, then 0, then 3.
- Mid-stream reset: assert `rst_n`=0 while `out_valid`=1. Require `out_valid`=0 with no clock edge. After release, the round-robin sequence restarts at channel 0.
